// File: rtl/maxnet_update.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_update
// Description : MAXNET winner-take-all sequencer. Loads four IEEE-754
//               activations and drives an external PLU for one weighted sum
//               per neuron. All four new values are committed together
//               (Jacobi update). The module stops when a single nonzero
//               activation remains, when all activations are zero, on
//               iteration timeout, or when the PLU reports overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module maxnet_update #(
  parameter int MAX_ITER = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_in0,
  input  logic [31:0] a_in1,
  input  logic [31:0] a_in2,
  input  logic [31:0] a_in3,
  output logic        plu_start,
  input  logic        plu_done,
  input  logic [31:0] plu_out,
  input  logic        plu_overflow,
  output logic [31:0] act0,
  output logic [31:0] act1,
  output logic [31:0] act2,
  output logic [31:0] act3,
  output logic [1:0]  neuron_idx,
  output logic        done,
  output logic [1:0]  status,
  output logic [1:0]  winner,
  output logic [7:0]  iter_cnt
);

  localparam logic [7:0] c_MAX_ITER  = 8'(MAX_ITER);
  localparam logic [1:0] c_ST_WINNER = 2'b00;
  localparam logic [1:0] c_ST_ZERO   = 2'b01;
  localparam logic [1:0] c_ST_TMO    = 2'b10;
  localparam logic [1:0] c_ST_OVF    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CHECK  = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_COMMIT = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  state_t      r_state;
  logic [31:0] r_act [0:3];
  logic [31:0] r_shadow [0:3];
  logic [7:0]  r_iter;
  logic [1:0]  r_idx;
  logic [1:0]  r_status;
  logic [1:0]  r_winner;
  logic        r_plu_start;
  logic        r_done;

  logic [2:0]  w_nz_cnt;
  logic [1:0]  w_nz_idx;

  // Negative values (including -0) clamp to +0.
  function automatic logic [31:0] relu(input logic [31:0] v);
    return v[31] ? 32'h0 : v;
  endfunction

  // Count nonzero committed activations and remember the index of one of
  // them; the index is only used when the count is exactly one.
  always_comb begin
    w_nz_cnt = 3'd0;
    w_nz_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (r_act[k][30:0] != 31'h0) begin
        w_nz_cnt = w_nz_cnt + 3'd1;
        w_nz_idx = 2'(k);
      end
    end
  end

  // Sequencer: controls the PLU handshake, shadow capture and commit.
  // The act registers only change in LOAD and COMMIT, so the PLU sees the
  // previous iteration's values for all four neurons.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_iter      <= 8'd0;
      r_idx       <= 2'd0;
      r_status    <= 2'd0;
      r_winner    <= 2'd0;
      r_plu_start <= 1'b0;
      r_done      <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_act[k]    <= 32'h0;
        r_shadow[k] <= 32'h0;
      end
    end else begin
      r_plu_start <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_act[0] <= relu(a_in0);
          r_act[1] <= relu(a_in1);
          r_act[2] <= relu(a_in2);
          r_act[3] <= relu(a_in3);
          r_iter   <= 8'd0;
          r_idx    <= 2'd0;
          r_status <= 2'd0;
          r_winner <= 2'd0;
          r_state  <= S_CHECK;
        end
        S_CHECK: begin
          if (w_nz_cnt == 3'd1) begin
            r_status <= c_ST_WINNER;
            r_winner <= w_nz_idx;
            r_done   <= 1'b1;
            r_state  <= S_FIN;
          end else if (w_nz_cnt == 3'd0) begin
            r_status <= c_ST_ZERO;
            r_done   <= 1'b1;
            r_state  <= S_FIN;
          end else if (r_iter == c_MAX_ITER) begin
            r_status <= c_ST_TMO;
            r_done   <= 1'b1;
            r_state  <= S_FIN;
          end else begin
            r_idx       <= 2'd0;
            r_plu_start <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (plu_done) begin
            if (plu_overflow) begin
              r_status <= c_ST_OVF;
              r_done   <= 1'b1;
              r_state  <= S_FIN;
            end else begin
              r_shadow[r_idx] <= relu(plu_out);
              if (r_idx == 2'd3) begin
                r_state <= S_COMMIT;
              end else begin
                r_idx       <= r_idx + 2'd1;
                r_plu_start <= 1'b1;
                r_state     <= S_ISSUE;
              end
            end
          end
        end
        S_COMMIT: begin
          for (int k = 0; k < 4; k++) begin
            r_act[k] <= r_shadow[k];
          end
          if (r_iter != 8'hFF) begin
            r_iter <= r_iter + 8'd1;
          end
          r_state <= S_CHECK;
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign plu_start  = r_plu_start;
  assign done       = r_done;
  assign act0       = r_act[0];
  assign act1       = r_act[1];
  assign act2       = r_act[2];
  assign act3       = r_act[3];
  assign neuron_idx = r_idx;
  assign status     = r_status;
  assign winner     = r_winner;
  assign iter_cnt   = r_iter;

endmodule
`default_nettype wire
